// File: rtl/pair_dist_gen.sv
// ============================================================================
//  Module      : pair_dist_gen
//  Description : Stores a point set, then streams the squared distance of every
//                unordered point pair through a 3-stage pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pair_dist_gen #(
    parameter int NUM_POINTS = 1000,
    parameter int DIM_W      = 17,
    localparam int IW        = $clog2(NUM_POINTS),
    localparam int DW        = (DIM_W + 1) * 2 + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIM_W-1:0] pt_x,
    input  logic [DIM_W-1:0] pt_y,
    input  logic [DIM_W-1:0] pt_z,
    input  logic             pt_vld,
    input  logic             pt_last,
    output logic             busy,
    output logic [DW-1:0]    approx_dist,
    output logic [IW-1:0]    pointa_out,
    output logic [IW-1:0]    pointb_out,
    output logic             dist_vld,
    output logic             gen_done
);

    localparam int CW = $clog2(NUM_POINTS + 1);
    localparam int PW = 3 * DIM_W;
    localparam int SW = DIM_W + 1;
    localparam int QW = 2 * SW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   wr_cnt;
    logic [CW-1:0]   n_pts;
    logic [IW-1:0]   idx_i;
    logic [IW-1:0]   idx_j;
    logic [PW-1:0]   mem [NUM_POINTS];

    logic            s1_vld;
    logic [PW-1:0]   s1_a;
    logic [PW-1:0]   s1_b;
    logic [IW-1:0]   s1_ia;
    logic [IW-1:0]   s1_ib;

    logic            s2_vld;
    logic signed [SW-1:0] s2_dx;
    logic signed [SW-1:0] s2_dy;
    logic signed [SW-1:0] s2_dz;
    logic [IW-1:0]   s2_ia;
    logic [IW-1:0]   s2_ib;

    logic            w_load;
    logic            w_close;
    logic            w_issue;
    logic            w_j_end;
    logic            w_i_end;
    logic [CW-1:0]   w_n_m1;
    logic signed [SW-1:0] w_dx;
    logic signed [SW-1:0] w_dy;
    logic signed [SW-1:0] w_dz;
    logic signed [QW-1:0] w_ex;
    logic signed [QW-1:0] w_ey;
    logic signed [QW-1:0] w_ez;
    logic [QW-1:0]   w_sqx;
    logic [QW-1:0]   w_sqy;
    logic [QW-1:0]   w_sqz;
    logic [DW-1:0]   w_sum;

    always_comb begin
        w_load  = (state == IDLE) && pt_vld;
        w_close = w_load && (pt_last || (wr_cnt == CW'(NUM_POINTS - 1)));
        w_issue = (state == GEN) && (n_pts >= CW'(2));
        w_n_m1  = n_pts - CW'(1);
        w_j_end = (CW'(idx_j) == w_n_m1);
        w_i_end = (CW'(idx_i) == w_n_m1 - CW'(1));
    end

    // Storage is not reset; only the loaded entries are ever read.
    always_ff @(posedge clk) begin
        if (w_load) begin
            mem[wr_cnt[IW-1:0]] <= {pt_x, pt_y, pt_z};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_cnt   <= '0;
            n_pts    <= '0;
            idx_i    <= '0;
            idx_j    <= IW'(1);
            busy     <= 1'b0;
            gen_done <= 1'b0;
        end else begin
            gen_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (w_load) begin
                        wr_cnt <= wr_cnt + CW'(1);
                        if (w_close) begin
                            n_pts <= wr_cnt + CW'(1);
                            state <= GEN;
                            busy  <= 1'b1;
                        end
                    end
                end
                GEN: begin
                    if (n_pts < CW'(2)) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        gen_done <= 1'b1;
                    end else if (w_j_end && w_i_end) begin
                        state <= DRAIN;
                    end else if (w_j_end) begin
                        idx_i <= idx_i + IW'(1);
                        idx_j <= idx_i + IW'(2);
                    end else begin
                        idx_j <= idx_j + IW'(1);
                    end
                end
                DRAIN: begin
                    // Last pair is on the outputs once the earlier stages are empty.
                    if (dist_vld && !s1_vld && !s2_vld) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        gen_done <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    wr_cnt <= '0;
                    idx_i  <= '0;
                    idx_j  <= IW'(1);
                end
            endcase
        end
    end

    always_comb begin
        w_dx  = $signed({1'b0, s1_a[PW-1 -: DIM_W]})      - $signed({1'b0, s1_b[PW-1 -: DIM_W]});
        w_dy  = $signed({1'b0, s1_a[2*DIM_W-1 -: DIM_W]}) - $signed({1'b0, s1_b[2*DIM_W-1 -: DIM_W]});
        w_dz  = $signed({1'b0, s1_a[DIM_W-1:0]})          - $signed({1'b0, s1_b[DIM_W-1:0]});
        w_ex  = {{SW{s2_dx[SW-1]}}, s2_dx};
        w_ey  = {{SW{s2_dy[SW-1]}}, s2_dy};
        w_ez  = {{SW{s2_dz[SW-1]}}, s2_dz};
        w_sqx = QW'(w_ex * w_ex);
        w_sqy = QW'(w_ey * w_ey);
        w_sqz = QW'(w_ez * w_ez);
        w_sum = DW'(w_sqx) + DW'(w_sqy) + DW'(w_sqz);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld      <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_ia       <= '0;
            s1_ib       <= '0;
            s2_vld      <= 1'b0;
            s2_dx       <= '0;
            s2_dy       <= '0;
            s2_dz       <= '0;
            s2_ia       <= '0;
            s2_ib       <= '0;
            dist_vld    <= 1'b0;
            approx_dist <= '0;
            pointa_out  <= '0;
            pointb_out  <= '0;
        end else begin
            s1_vld <= w_issue;
            if (w_issue) begin
                s1_a  <= mem[idx_i];
                s1_b  <= mem[idx_j];
                s1_ia <= idx_i;
                s1_ib <= idx_j;
            end
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_dx <= w_dx;
                s2_dy <= w_dy;
                s2_dz <= w_dz;
                s2_ia <= s1_ia;
                s2_ib <= s1_ib;
            end
            dist_vld <= s2_vld;
            if (s2_vld) begin
                approx_dist <= w_sum;
                pointa_out  <= s2_ia;
                pointb_out  <= s2_ib;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pair_dist_gen.sv
// ============================================================================
//  Module      : tb_pair_dist_gen
//  Description : Directed bench for pair_dist_gen with a timing/pair model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pair_dist_gen;

    localparam int DW = 38;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [16:0]   px [2];
    logic [16:0]   py [2];
    logic [16:0]   pz [2];
    logic          pv [2];
    logic          pl [2];
    logic          busy_v [2];
    logic          dv_v [2];
    logic          gd_v [2];
    logic [DW-1:0] ad_v [2];
    logic [9:0]    pa0, pb0;
    logic [1:0]    pa1, pb1;

    pair_dist_gen dut (
        .clk(clk), .rst(rst),
        .pt_x(px[0]), .pt_y(py[0]), .pt_z(pz[0]), .pt_vld(pv[0]), .pt_last(pl[0]),
        .busy(busy_v[0]), .approx_dist(ad_v[0]), .pointa_out(pa0), .pointb_out(pb0),
        .dist_vld(dv_v[0]), .gen_done(gd_v[0])
    );

    pair_dist_gen #(.NUM_POINTS(4), .DIM_W(17)) dut4 (
        .clk(clk), .rst(rst),
        .pt_x(px[1]), .pt_y(py[1]), .pt_z(pz[1]), .pt_vld(pv[1]), .pt_last(pl[1]),
        .busy(busy_v[1]), .approx_dist(ad_v[1]), .pointa_out(pa1), .pointb_out(pb1),
        .dist_vld(dv_v[1]), .gen_done(gd_v[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: stored points, cycle of the closing load, set size, activity.
    int     mx [2][16];
    int     my [2][16];
    int     mz [2][16];
    int     mk [2];
    int     mn [2];
    bit     mact [2];
    int     tx [16];
    int     ty [16];
    int     tz [16];
    longint obsd [$];
    int     obsab [$];
    longint obsd4 [$];
    int     obsab4 [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint mdist(input int d, input int a, input int b);
        longint dx, dy, dz;
        dx = longint'(mx[d][a]) - longint'(mx[d][b]);
        dy = longint'(my[d][a]) - longint'(my[d][b]);
        dz = longint'(mz[d][a]) - longint'(mz[d][b]);
        return dx * dx + dy * dy + dz * dz;
    endfunction

    task automatic pair_of(input int n, input int p, output int a, output int b);
        int c;
        c = 0; a = -1; b = -1;
        for (int x = 0; x < n; x++)
            for (int y = x + 1; y < n; y++) begin
                if (c == p) begin a = x; b = y; end
                c++;
            end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                int t, np, lastb, p, a, b, acta, actb;
                bit ev, ed, eb;
                t = cyc; ev = 0; ed = 0; eb = 0;
                acta = (d == 0) ? int'(pa0) : int'(pa1);
                actb = (d == 0) ? int'(pb0) : int'(pb1);
                if (mact[d]) begin
                    np    = mn[d] * (mn[d] - 1) / 2;
                    ev    = (t >= mk[d] + 4) && (t < mk[d] + 4 + np);
                    ed    = (mn[d] >= 2) ? (t == mk[d] + 4 + np) : (t == mk[d] + 2);
                    lastb = (np > 0) ? mk[d] + np + 3 : mk[d] + 1;
                    eb    = (t >= mk[d] + 1) && (t <= lastb);
                end
                chk(d == 0 ? "dist_vld" : "dist_vld4", 64'(dv_v[d]), 64'(ev));
                chk(d == 0 ? "gen_done" : "gen_done4", 64'(gd_v[d]), 64'(ed));
                chk(d == 0 ? "busy" : "busy4", 64'(busy_v[d]), 64'(eb));
                if (ev && dv_v[d] === 1'b1) begin
                    p = t - (mk[d] + 4);
                    pair_of(mn[d], p, a, b);
                    chk("pointa", 64'(acta), 64'(a));
                    chk("pointb", 64'(actb), 64'(b));
                    chk("approx_dist", 64'(ad_v[d]), 64'(mdist(d, a, b)));
                end
                if (dv_v[d] === 1'b1) begin
                    if (d == 0) begin obsd.push_back(longint'(ad_v[0])); obsab.push_back(acta * 100 + actb); end
                    else        begin obsd4.push_back(longint'(ad_v[1])); obsab4.push_back(acta * 100 + actb); end
                end
                if (mact[d] && ed) mact[d] = 0;
            end
        end
    end

    task automatic setp(input int k, input int x, input int y, input int z);
        tx[k] = x; ty[k] = y; tz[k] = z;
    endtask

    task automatic load(input int d, input int cnt, input int cap, input bit use_last);
        int n;
        n = (cnt < cap) ? cnt : cap;
        for (int k = 0; k < cnt; k++) begin
            px[d] = 17'(tx[k]); py[d] = 17'(ty[k]); pz[d] = 17'(tz[k]);
            pv[d] = 1'b1;
            pl[d] = use_last && (k == cnt - 1);
            if (k < n) begin mx[d][k] = tx[k]; my[d][k] = ty[k]; mz[d][k] = tz[k]; end
            if (k == n - 1) begin mk[d] = cyc; mn[d] = n; mact[d] = 1; end
            @(posedge clk); #1;
        end
        pv[d] = 1'b0; pl[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int w;
        w = 0;
        while (mact[d] && w < 300) begin @(posedge clk); #1; w++; end
        chk("run_timeout", 64'(mact[d]), 64'd0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy_v[0]), 64'd0);
        chk({tag, "_dist_vld"}, 64'(dv_v[0]), 64'd0);
        chk({tag, "_gen_done"}, 64'(gd_v[0]), 64'd0);
        chk({tag, "_approx_dist"}, 64'(ad_v[0]), 64'd0);
        chk({tag, "_pointa"}, 64'(pa0), 64'd0);
        chk({tag, "_pointb"}, 64'(pb0), 64'd0);
    endtask

    task automatic basic_set();
        setp(0, 0, 0, 0); setp(1, 1, 2, 2); setp(2, 3, 0, 4);
    endtask

    task automatic check_basic(input string tag);
        chk({tag, "_count"}, 64'(obsd.size()), 64'd3);
        if (obsd.size() == 3) begin
            chk({tag, "_d01"}, 64'(obsd[0]), 64'd9);
            chk({tag, "_d02"}, 64'(obsd[1]), 64'd25);
            chk({tag, "_d12"}, 64'(obsd[2]), 64'd12);
            chk({tag, "_ab0"}, 64'(obsab[0]), 64'd1);
            chk({tag, "_ab1"}, 64'(obsab[1]), 64'd2);
            chk({tag, "_ab2"}, 64'(obsab[2]), 64'd102);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            px[d] = '0; py[d] = '0; pz[d] = '0; pv[d] = 1'b0; pl[d] = 1'b0;
            mact[d] = 0; mk[d] = 0; mn[d] = 0;
        end
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Basic three-point set
        basic_set();
        obsd.delete(); obsab.delete();
        load(0, 3, 1000, 1);
        wait_idle(0);
        check_basic("basic");

        // Full-range coordinates
        setp(0, 0, 0, 0); setp(1, 131071, 131071, 131071);
        obsd.delete(); obsab.delete();
        load(0, 2, 1000, 1);
        wait_idle(0);
        chk("full_count", 64'(obsd.size()), 64'd1);
        if (obsd.size() == 1) chk("full_dist", 64'(obsd[0]), 64'd51538821123);

        // Single point
        setp(0, 7, 8, 9);
        obsd.delete(); obsab.delete();
        load(0, 1, 1000, 1);
        wait_idle(0);
        chk("single_count", 64'(obsd.size()), 64'd0);

        // Auto-close at capacity; fifth point lands during GEN
        setp(0, 0, 0, 0); setp(1, 1, 0, 0); setp(2, 0, 2, 0); setp(3, 0, 0, 3); setp(4, 5, 5, 5);
        obsd4.delete(); obsab4.delete();
        load(1, 5, 4, 0);
        wait_idle(1);
        chk("auto_count", 64'(obsd4.size()), 64'd6);
        if (obsd4.size() == 6) begin
            chk("auto_d0", 64'(obsd4[0]), 64'd1);
            chk("auto_d1", 64'(obsd4[1]), 64'd4);
            chk("auto_d2", 64'(obsd4[2]), 64'd9);
            chk("auto_d3", 64'(obsd4[3]), 64'd5);
            chk("auto_d4", 64'(obsd4[4]), 64'd10);
            chk("auto_d5", 64'(obsd4[5]), 64'd13);
            chk("auto_ab5", 64'(obsab4[5]), 64'd203);
        end

        // Reset in the middle of GEN of a 10-point set
        for (int k = 0; k < 10; k++) setp(k, k * 3, k * k, 100 - k);
        load(0, 10, 1000, 1);
        while (cyc < mk[0] + 6) begin @(posedge clk); #1; end
        #1;
        rst = 1'b1;
        mact[0] = 0;
        #1;
        check_zero("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        basic_set();
        obsd.delete(); obsab.delete();
        load(0, 3, 1000, 1);
        wait_idle(0);
        check_basic("after_reset");

        // Loads during GEN and DRAIN must be ignored
        basic_set();
        obsd.delete(); obsab.delete();
        load(0, 3, 1000, 1);
        for (int k = 0; k < 5; k++) begin
            px[0] = 17'd9; py[0] = 17'd9; pz[0] = 17'd9; pv[0] = 1'b1; pl[0] = 1'b1;
            @(posedge clk); #1;
        end
        pv[0] = 1'b0; pl[0] = 1'b0;
        wait_idle(0);
        check_basic("perturbed");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pair_dist_gen.md
PAIR_DIST_GEN -- requirements
Module: pair_dist_gen

Interface
REQ-001 SHALL have parameter NUM_POINTS, default 1000, the maximum number of stored points.
REQ-002 SHALL have parameter DIM_W, default 17, the unsigned width of each coordinate.
REQ-003 SHALL define IW = $clog2(NUM_POINTS) and DW = (DIM_W+1)*2+2.
REQ-004 SHALL have port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports pt_x, pt_y and pt_z, input, DIM_W each: the coordinates of the point being loaded.
REQ-007 SHALL have port pt_vld, input, 1: the point is valid this cycle.
REQ-008 SHALL have port pt_last, input, 1: qualified by pt_vld; the point is the final one in the set.
REQ-009 SHALL have port busy, output, 1: high in GEN and DRAIN.
REQ-010 SHALL have port approx_dist, output, DW: the squared Euclidean distance of the pair.
REQ-011 SHALL have ports pointa_out and pointb_out, output, IW each: the pair indices, with pointa_out < pointb_out.
REQ-012 SHALL have port dist_vld, output, 1: approx_dist, pointa_out and pointb_out are valid this cycle.
REQ-013 SHALL have port gen_done, output, 1: a one-cycle pulse when all pairs have been emitted.

Function
REQ-014 SHALL implement states IDLE, GEN, DRAIN and DONE.
REQ-015 IDLE: each pt_vld writes {pt_x, pt_y, pt_z} to storage index wr_cnt, then increments wr_cnt.
REQ-016 IDLE: pt_vld with pt_last, or pt_vld when wr_cnt == NUM_POINTS-1, SHALL latch N = wr_cnt+1 and go to GEN the next cycle.
REQ-017 SHALL ignore pt_vld outside IDLE: no write and no change to wr_cnt.
REQ-018 GEN with N < 2 SHALL go directly to DONE without asserting dist_vld.
REQ-019 GEN SHALL issue exactly one pair per cycle with no gaps.
REQ-020 Pair order SHALL be (0,1), (0,2) ... (0,N-1), (1,2) ... (N-2,N-1), for N*(N-1)/2 pairs in total.
REQ-021 Index update SHALL be: j increments; when j == N-1, i increments and j = i+2 (the new i plus 1).
REQ-022 Issuing pair (N-2,N-1) SHALL move the state to DRAIN.
REQ-023 Datapath SHALL be a 3-stage pipeline: stage 1 reads both points; stage 2 forms signed (DIM_W+1)-bit differences dx, dy, dz; stage 3 forms the squares and their sum.
REQ-024 A pair issued in cycle t SHALL appear on the outputs with dist_vld=1 in cycle t+3.
REQ-025 Squares SHALL be exact 2*(DIM_W+1)-bit unsigned values, and the sum SHALL be zero-extended to DW bits with no truncation or saturation.
REQ-026 pointa_out and pointb_out SHALL travel through the pipeline alongside the distance data.
REQ-027 DRAIN SHALL last until the last pair exits the pipeline, then go to DONE.
REQ-028 DONE SHALL assert gen_done for exactly one cycle, clear wr_cnt, and return to IDLE.
REQ-029 gen_done SHALL assert in the cycle after the final dist_vld, and in the cycle after GEN when N < 2.
REQ-030 When dist_vld=0, approx_dist, pointa_out and pointb_out SHALL hold their last values; their content is don't-care.
REQ-031 Point storage SHALL allow two reads per cycle, either two read ports or point i held in a register while j is read.
REQ-032 Storage read latency SHALL be accounted for in the 3-cycle latency.
REQ-033 There SHALL be no backpressure input; the downstream block consumes every cycle.

Reset
REQ-034 rst=1 SHALL asynchronously force state=IDLE, wr_cnt=0, N=0, i=0, j=1 and all pipeline valids=0.
REQ-035 rst=1 SHALL asynchronously force busy=0, dist_vld=0, gen_done=0, approx_dist=0, pointa_out=0 and pointb_out=0.
REQ-036 Point storage contents SHALL NOT be reset.
REQ-037 Reset mid-GEN or mid-DRAIN SHALL discard in-flight pairs; no dist_vld or gen_done SHALL follow the reset.

Verification
REQ-038 Basic set: load (0,0,0), (1,2,2), (3,0,4) with pt_last on the third point -> dist_vld high 3 consecutive cycles with (0,1,9), (0,2,25), (1,2,12), then gen_done high 1 cycle.
REQ-039 Full-range distance: load (0,0,0) and (131071,131071,131071) -> one output (0,1,51538821123), with no overflow in 38 bits.
REQ-040 Single point: one point with pt_last -> no dist_vld, gen_done pulse 1 cycle after GEN, busy never high for more than 1 cycle.
REQ-041 Auto-last: with NUM_POINTS=4, send 5 points without pt_last -> the 4th point closes the load, the 5th is ignored, 6 pairs are emitted in order.
REQ-042 Reset mid-operation: assert rst during GEN of a 10-point set -> outputs 0 in the same cycle, no gen_done; a subsequent 3-point load reproduces the REQ-038 results.
REQ-043 Load during generation: pt_vld pulses during GEN and DRAIN -> wr_cnt unchanged, output sequence identical to the unperturbed run.
